// File: rtl/result_bank.sv
// rtl/result_bank.sv - double-buffered sequencer result store feeding I2S left/right and host reads
// Optional per-slot peak tracking is enabled with `define RESULT_PEAK_EN.
module result_bank #(
  parameter int SLOTS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_data,
  input  logic              in_done,
  input  logic              frame_strobe,
  input  logic [ADDR_W-1:0] left_sel,
  input  logic [ADDR_W-1:0] right_sel,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [15:0]       host_rdata,
  input  logic              status_clr,
  output logic [15:0]       left,
  output logic [15:0]       right,
  output logic              bank,
  output logic              overrun,
  output logic              underrun,
  output logic [15:0]       peak
);

  logic [15:0] mem [2][SLOTS];
  logic        pending;
  logic        done_q;
  logic        update_q;
  logic        done_edge;
  logic        swap;

  assign done_edge = in_done && !done_q;
  // pending is the registered value, so a done edge landing on a strobe cannot swap this frame
  assign swap      = frame_strobe && pending;

  always_ff @(posedge ck) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < SLOTS; i++)
          mem[b][i] <= '0;
      bank       <= 1'b0;
      pending    <= 1'b0;
      done_q     <= 1'b0;
      update_q   <= 1'b0;
      left       <= '0;
      right      <= '0;
      host_rdata <= '0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done_q <= in_done;

      if (in_we && !pending)
        mem[~bank][in_addr] <= in_data;

      if (swap)
        bank <= ~bank;

      if (done_edge)
        pending <= 1'b1;
      else if (swap)
        pending <= 1'b0;

      // routing is sampled once, the cycle after the swap, from the new read bank
      update_q <= swap;
      if (update_q) begin
        left  <= mem[bank][left_sel];
        right <= mem[bank][right_sel];
      end

      host_rdata <= mem[bank][host_raddr];

      if (in_we && pending)
        overrun <= 1'b1;
      else if (status_clr)
        overrun <= 1'b0;

      if (frame_strobe && !pending)
        underrun <= 1'b1;
      else if (status_clr)
        underrun <= 1'b0;
    end
  end

`ifdef RESULT_PEAK_EN
  logic [15:0] peak_r [SLOTS];
  logic [15:0] peak_q;

  function automatic logic [15:0] mag(input logic [15:0] v);
    if (v == 16'h8000)
      return 16'h7fff;
    else if (v[15])
      return 16'(-v);
    else
      return v;
  endfunction

  function automatic logic [15:0] peak_next(input logic [15:0] old, input logic [15:0] val,
                                            input logic clr, input logic upd);
    logic [15:0] base;
    base = clr ? 16'h0000 : old;
    if (upd && (mag(val) > base))
      return mag(val);
    else
      return base;
  endfunction

  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++)
        peak_r[i] <= '0;
      peak_q <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++)
        peak_r[i] <= peak_next(peak_r[i], mem[~bank][i], status_clr, swap);
      peak_q <= peak_r[host_raddr];
    end
  end

  assign peak = peak_q;
`else
  assign peak = 16'h0000;
`endif

endmodule

// File: tb/tb_result_bank.sv
// tb/tb_result_bank.sv - table-driven bench for result_bank
module tb_result_bank;

  logic        ck = 1'b0;
  logic        reset;
  logic        in_we;
  logic [3:0]  in_addr;
  logic [15:0] in_data;
  logic        in_done;
  logic        frame_strobe;
  logic [3:0]  left_sel;
  logic [3:0]  right_sel;
  logic [3:0]  host_raddr;
  logic [15:0] host_rdata;
  logic        status_clr;
  logic [15:0] left;
  logic [15:0] right;
  logic        bank;
  logic        overrun;
  logic        underrun;
  logic [15:0] peak;

  int n_cmp  = 0;
  int n_fail = 0;

  result_bank #(.SLOTS(16), .ADDR_W(4)) dut (
    .ck(ck), .reset(reset), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .in_done(in_done), .frame_strobe(frame_strobe), .left_sel(left_sel),
    .right_sel(right_sel), .host_raddr(host_raddr), .host_rdata(host_rdata),
    .status_clr(status_clr), .left(left), .right(right), .bank(bank),
    .overrun(overrun), .underrun(underrun), .peak(peak)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        done;
    logic        fs;
    logic [3:0]  lsel;
    logic [3:0]  rsel;
    logic [3:0]  hraddr;
    logic        clr;
    logic [15:0] e_left;
    logic [15:0] e_right;
    logic        e_bank;
    logic        e_ov;
    logic        e_un;
    logic [15:0] e_host;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_we = 1'b0; in_addr = 4'd0; in_data = 16'h0000; frame_strobe = 1'b0; status_clr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic frame(input logic [15:0] v);
    idle(); in_done = 1'b0; in_we = 1'b1; in_addr = 4'd3; in_data = v; cyc();
    idle(); in_done = 1'b1; cyc();
    idle(); frame_strobe = 1'b1; cyc();
    idle(); in_done = 1'b0; cyc();
    cyc();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd0, 16'h1234, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 4'd1, 16'hABCD, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 4'd2, 16'h5555, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'hABCD};
    tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h2222};
    tbl[8]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'hABCD};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'hABCD};
    tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd2, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'hABCD};
    tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd2, 4'd1, 4'd1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'hABCD};
    tbl[12] = '{1'b1, 4'd0, 16'h0AAA, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'hABCD};
    tbl[13] = '{1'b1, 4'd1, 16'h0BBB, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'hABCD};
    tbl[14] = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'hABCD};
    tbl[15] = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b1, 16'hABCD};
    tbl[16] = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 1'b0, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0, 1'b1, 16'h0BBB};

    idle();
    in_done = 1'b0; left_sel = 4'd0; right_sel = 4'd1; host_raddr = 4'd1;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk("reset_left", left, 16'h0000);
    chk("reset_right", right, 16'h0000);
    chk("reset_bank", {15'd0, bank}, 16'h0000);
    chk("reset_flags", {14'd0, overrun, underrun}, 16'h0000);
    chk("reset_host", host_rdata, 16'h0000);
    chk("reset_peak", peak, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      in_we = tbl[i].we; in_addr = tbl[i].addr; in_data = tbl[i].data;
      in_done = tbl[i].done; frame_strobe = tbl[i].fs; left_sel = tbl[i].lsel;
      right_sel = tbl[i].rsel; host_raddr = tbl[i].hraddr; status_clr = tbl[i].clr;
      cyc();
      chk($sformatf("v%0d_left", i), left, tbl[i].e_left);
      chk($sformatf("v%0d_right", i), right, tbl[i].e_right);
      chk($sformatf("v%0d_bank", i), {15'd0, bank}, {15'd0, tbl[i].e_bank});
      chk($sformatf("v%0d_overrun", i), {15'd0, overrun}, {15'd0, tbl[i].e_ov});
      chk($sformatf("v%0d_underrun", i), {15'd0, underrun}, {15'd0, tbl[i].e_un});
      chk($sformatf("v%0d_host", i), host_rdata, tbl[i].e_host);
    end

    // reset while a completed bank is pending: the pending swap must be forgotten
    idle(); in_done = 1'b0; left_sel = 4'd0; right_sel = 4'd1; cyc();
    in_done = 1'b1; cyc();
    in_done = 1'b0; reset = 1'b1; cyc();
    reset = 1'b0; cyc();
    frame_strobe = 1'b1; cyc();
    idle(); cyc(); cyc();
    chk("rst_pend_bank", {15'd0, bank}, 16'h0000);
    chk("rst_pend_left", left, 16'h0000);
    chk("rst_pend_right", right, 16'h0000);
    chk("rst_pend_underrun", {15'd0, underrun}, 16'h0001);

    status_clr = 1'b1; cyc(); idle();
    host_raddr = 4'd3;
    frame(16'h0100);
    chk("pk_bank1", {15'd0, bank}, 16'h0001);
    chk("pk_host1", host_rdata, 16'h0100);
    frame(16'hFF00);
    chk("pk_host2", host_rdata, 16'hFF00);
`ifdef RESULT_PEAK_EN
    chk("pk_peak2", peak, 16'h0100);
`else
    chk("pk_peak2_off", peak, 16'h0000);
`endif
    frame(16'h8000);
    chk("pk_host3", host_rdata, 16'h8000);
`ifdef RESULT_PEAK_EN
    chk("pk_peak3", peak, 16'h7FFF);
`else
    chk("pk_peak3_off", peak, 16'h0000);
`endif
    chk("pk_underrun", {15'd0, underrun}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_bank.md
Name: result_bank

Overview:
- Double-buffered store for the sequencer's per-frame results. It sits between the sequencer output port (out_we / out_addr / out_audio) and the I2S transmitter left/right inputs.
- The sequencer fills the write bank during a frame. Banks swap on the next I2S frame strobe once the sequencer has signalled done.
- This gives the transmitter and the host a stable, glitch-free result set.
- Routing registers select which slots drive I2S left and right.

Parameters:
- SLOTS, 16, number of 16-bit result words per bank.
- ADDR_W, 4, slot address width; must equal $clog2(SLOTS).

Ports:
- ck  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- in_we  in  1  sequencer result write strobe
- in_addr  in  ADDR_W  sequencer result slot
- in_data  in  16  sequencer result sample
- in_done  in  1  sequencer done level; its rising edge marks the write bank complete
- frame_strobe  in  1  one-cycle pulse at I2S frame start (ws && frame_posn==0)
- left_sel  in  ADDR_W  slot routed to I2S left
- right_sel  in  ADDR_W  slot routed to I2S right
- host_raddr  in  ADDR_W  host read slot
- host_rdata  out  16  host read data from the read bank, 1-cycle latency
- status_clr  in  1  pulse; clears sticky flags
- left  out  16  I2S left sample
- right  out  16  I2S right sample
- bank  out  1  index of the current read bank
- overrun  out  1  sticky: sequencer write dropped because the write bank was already complete
- underrun  out  1  sticky: frame_strobe arrived with no completed bank
- peak  out  16  peak magnitude of host_raddr slot (RESULT_PEAK_EN only, else 0)

Behaviour:
- Reset: all bank words 0; bank=0; pending=0; done_q=0; left, right, host_rdata, overrun, underrun, peak all 0.
- Storage: 2*SLOTS flops. Write bank = !bank.
- Done edge: done_q registers in_done. On in_done && !done_q, set pending=1.
- Write:
  - in_we && !pending: store in_data at [!bank][in_addr].
  - in_we && pending: write dropped, overrun<=1.
- frame_strobe && pending (pending as registered before this cycle):
  - bank<=!bank, pending<=0.
  - Next cycle: left<=new_read[left_sel], right<=new_read[right_sel].
  - Outputs update exactly 1 cycle after the swap; i.e. left/right are valid 2 cycles after frame_strobe.
- frame_strobe && !pending: no swap; left/right hold their previous values; underrun<=1.
- Simultaneous events:
  - Done edge and frame_strobe in the same cycle: no swap this frame, underrun set, pending set. The swap happens on the next frame_strobe.
  - in_we in the swap cycle: the address is decoded against the pre-swap bank; the write is dropped as overrun because pending=1.
- left_sel / right_sel are sampled only at the swap-update cycle. Changing them mid-frame has no effect until the next swap.
- host_rdata <= [bank][host_raddr] every cycle; registered, 1-cycle latency.
- status_clr clears overrun and underrun. If a set condition coincides with status_clr, set wins.
- Reset mid-frame discards both banks and pending; the first swap requires a fresh done edge.

Optional Feature:
- Macro: RESULT_PEAK_EN.
- Defined:
  - Each of the SLOTS slots has a 16-bit peak register.
  - On each swap, every slot's peak becomes max(peak, |value|), using the new read bank value. |-32768| saturates to 32767.
  - peak outputs peak[host_raddr], registered alongside host_rdata.
  - status_clr also zeroes all peaks; reset zeroes them.
- Undefined: peak is tied to 0 and no peak registers are generated.

Test Plan:
- Reset, write slot0=0x1234 and slot1=0xABCD, pulse in_done, then frame_strobe with left_sel=0, right_sel=1:
  - 2 cycles after the strobe, left=0x1234, right=0xABCD and bank=1.
  - Host read of addr 1 returns 0xABCD after 1 cycle.
- frame_strobe with no done edge since the last swap:
  - left/right and bank unchanged; underrun=1.
  - status_clr pulse -> underrun=0.
- Done edge, then in_we to slot 2 = 0x5555 before frame_strobe:
  - overrun=1.
  - After the swap, host read of slot 2 returns the pre-overrun value, not 0x5555.
- Done edge in the same cycle as frame_strobe: no swap and underrun=1; the next frame_strobe swaps with bank toggled.
- Assert reset while pending=1, then pulse frame_strobe: no swap, bank=0, left=right=0.
- RESULT_PEAK_EN: over two frames, slot3 values 0x0100 then 0xFF00 (-256) -> peak for slot3 reads 0x0100. Slot3 value 0x8000 -> peak=0x7FFF.
